ahb_program_sequencer: RTL and testbench

Fetch/decode/issue controller between the 1024x23 instruction memory and the AHB master command port. It owns the program counter and reads one instruction word per step. Each word is decoded as WRITE(1) BURST(3) SEL(1) ADDR(10) DATA(8) and issued as one command to the AHB master. The sequencer waits for completion, then advances. It runs a stored test program with no host intervention.

---
 rtl/ahb_program_sequencer.sv | 146 ++++++++++++++
 tb/tb_ahb_program_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_program_sequencer.sv
// Fetch/decode/issue sequencer: walks a stored program and issues each word as one AHB master command.
// Optional `STEP_MODE_EN adds a `step` input and a PAUSE state between instructions.
module ahb_program_sequencer #(
    parameter logic [9:0] END_PC       = 10'd35,
    parameter logic       HALT_ON_ZERO = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        start,
    input  logic        stop,
`ifdef STEP_MODE_EN
    input  logic        step,
`endif
    input  logic [22:0] instruction,
    output logic [9:0]  pc,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    input  logic        cmd_done,
    input  logic [7:0]  cmd_rdata,
    output logic        cmd_write,
    output logic [2:0]  cmd_burst,
    output logic        cmd_sel,
    output logic [9:0]  cmd_addr,
    output logic [7:0]  cmd_wdata,
    output logic [7:0]  last_rdata,
    output logic        busy,
    output logic        halted,
    output logic [2:0]  dbg_state
);

    // Command handshake: a command transfers on any edge where cmd_valid && cmd_ready;
    // cmd_valid never drops and the cmd_* fields never change until that edge.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_NEXT  = 3'd4,
        S_HALT  = 3'd5
`ifdef STEP_MODE_EN
        , S_PAUSE = 3'd6
`endif
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [9:0]  r_pc;
    logic [9:0]  w_pc_next;
    logic [22:0] r_ir;
    logic [22:0] w_ir_next;
    logic [7:0]  r_last_rdata;
    logic [7:0]  w_last_next;
    logic        w_at_end;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state      <= S_IDLE;
            r_pc         <= 10'd0;
            r_ir         <= 23'd0;
            r_last_rdata <= 8'd0;
        end else begin
            r_state      <= w_next_state;
            r_pc         <= w_pc_next;
            r_ir         <= w_ir_next;
            r_last_rdata <= w_last_next;
        end
    end

    assign w_at_end = (r_pc == END_PC) || (r_pc == 10'h3FF);

    always_comb begin
        w_next_state = r_state;
        w_pc_next    = r_pc;
        w_ir_next    = r_ir;
        w_last_next  = r_last_rdata;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_FETCH;
                    w_pc_next    = 10'd0;
                end
            end
            S_FETCH: begin
                w_ir_next = instruction;
                if (HALT_ON_ZERO && (instruction == 23'd0)) w_next_state = S_HALT;
                else                                        w_next_state = S_ISSUE;
            end
            S_ISSUE: begin
                // A done arriving together with ready completes the instruction immediately.
                if (cmd_ready) begin
                    if (cmd_done) begin
                        w_next_state = S_NEXT;
                        if (!r_ir[22]) w_last_next = cmd_rdata;
                    end else begin
                        w_next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cmd_done) begin
                    w_next_state = S_NEXT;
                    if (!r_ir[22]) w_last_next = cmd_rdata;
                end
            end
            S_NEXT: begin
                if (stop || w_at_end) begin
                    w_next_state = S_HALT;
                end else begin
                    w_pc_next = r_pc + 10'd1;
`ifdef STEP_MODE_EN
                    w_next_state = S_PAUSE;
`else
                    w_next_state = S_FETCH;
`endif
                end
            end
            S_HALT: begin
                if (start) begin
                    w_next_state = S_FETCH;
                    w_pc_next    = 10'd0;
                end
            end
`ifdef STEP_MODE_EN
            S_PAUSE: begin
                if (stop)      w_next_state = S_HALT;
                else if (step) w_next_state = S_FETCH;
            end
`endif
            default: w_next_state = S_IDLE;
        endcase
    end

    assign pc         = r_pc;
    assign cmd_valid  = (r_state == S_ISSUE);
    assign cmd_write  = r_ir[22];
    assign cmd_burst  = r_ir[21:19];
    assign cmd_sel    = r_ir[18];
    assign cmd_addr   = r_ir[17:8];
    assign cmd_wdata  = r_ir[7:0];
    assign last_rdata = r_last_rdata;
    assign busy       = (r_state == S_FETCH) || (r_state == S_ISSUE) ||
                        (r_state == S_WAIT)  || (r_state == S_NEXT);
    assign halted     = (r_state == S_HALT);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_ahb_program_sequencer.sv
// Bench for ahb_program_sequencer: program-walk reference model, AHB master responder, directed scenarios.
module tb_ahb_program_sequencer;

  localparam logic [9:0] END_PC = 10'd35;

  logic        HCLK = 1'b0;
  logic        HRESET, start, stop, step;
  logic [22:0] instruction;
  logic [9:0]  pc;
  logic        cmd_valid, cmd_ready, cmd_done;
  logic [7:0]  cmd_rdata;
  logic        cmd_write, cmd_sel;
  logic [2:0]  cmd_burst;
  logic [9:0]  cmd_addr;
  logic [7:0]  cmd_wdata, last_rdata;
  logic        busy, halted;
  logic [2:0]  dbg_state;

  logic [22:0] mem [1024];
  assign instruction = mem[pc];

  ahb_program_sequencer #(.END_PC(END_PC), .HALT_ON_ZERO(1'b1)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .stop(stop),
`ifdef STEP_MODE_EN
    .step(step),
`endif
    .instruction(instruction), .pc(pc), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_done(cmd_done), .cmd_rdata(cmd_rdata), .cmd_write(cmd_write), .cmd_burst(cmd_burst),
    .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .last_rdata(last_rdata),
    .busy(busy), .halted(halted), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 HCLK = ~HCLK;

  int n_vec = 0;
  int n_err = 0;

  // scoreboard: expected commands as {pc, word}
  logic [32:0] exp_q[$];
  logic [7:0]  exp_last = 8'd0;
  logic        chk_en = 1'b0;

  // master model state
  int          lat_wr = 1, lat_rd = 1, stall_left = 0, stall_seen = 0, m_cnt = 0, hs_cnt = 0;
  logic        m_read = 1'b0, m_live = 1'b0;
  logic [7:0]  m_rdata = 8'd0;
  logic [22:0] first_cmd = 23'd0;

  function automatic logic [7:0] slave_data(input logic [9:0] a);
    return (a == 10'd9) ? 8'hA5 : (a[7:0] ^ 8'h3C);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Expected command stream: walk the program from pc 0 until a zero word, stop point or end.
  function automatic int push_prog(input int stop_pc);
    int p;
    p = 0;
    forever begin
      if (mem[p] == 23'd0) return p;
      exp_q.push_back({10'(p), mem[p]});
      if (p == stop_pc || p == int'(END_PC) || p == 1023) return p;
      p++;
    end
  endfunction

  task automatic load_prog();
    for (int i = 0; i < 1024; i++) mem[i] = 23'd0;
    for (int i = 0; i <= 35; i++) begin
      if (i % 2 == 0) mem[i] = {1'b1, 3'((i >> 1) & 7), 1'b1, 10'(i + 1), 8'(i + 1)};
      else            mem[i] = {1'b0, 3'd0, 1'b0, 10'(i + 8), 8'(i * 3)};
    end
  endtask

  // compare process + master responder, both on the falling edge
  always @(negedge HCLK) begin
    logic [32:0] head;
    int lat;
    if (chk_en) begin
      chk("last_rdata", last_rdata, exp_last);
      if (cmd_valid) begin
        chk("cmd_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          head = exp_q[0];
          chk("cmd_write", cmd_write, head[22]);
          chk("cmd_burst", cmd_burst, head[21:19]);
          chk("cmd_sel", cmd_sel, head[18]);
          chk("cmd_addr", cmd_addr, head[17:8]);
          chk("cmd_wdata", cmd_wdata, head[7:0]);
          chk("cmd_pc", pc, head[32:23]);
        end
      end
    end
    cmd_done = 1'b0;
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        cmd_done  = 1'b1;
        cmd_rdata = m_rdata;
        if (m_live && m_read) exp_last = m_rdata;
      end
    end
    if (stall_left > 0) begin
      cmd_ready = 1'b0;
      if (cmd_valid) begin
        stall_left--;
        stall_seen++;
      end
    end else begin
      cmd_ready = 1'b1;
    end
    if (cmd_valid && cmd_ready) begin
      hs_cnt++;
      if (hs_cnt == 1) first_cmd = {cmd_write, cmd_burst, cmd_sel, cmd_addr, cmd_wdata};
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      m_read  = !cmd_write;
      m_rdata = slave_data(cmd_addr);
      m_live  = 1'b1;
      lat     = m_read ? lat_rd : lat_wr;
      if (lat == 0) begin
        cmd_done  = 1'b1;
        cmd_rdata = m_rdata;
        if (m_read) exp_last = m_rdata;
      end else begin
        m_cnt = lat;
      end
    end
    if (HRESET) begin
      exp_last = 8'd0;
      exp_q.delete();
      m_live = 1'b0;
    end
  end

  // driver tasks (inputs change 1 time unit after the rising edge)
  task automatic do_reset();
    HRESET = 1'b1; start = 1'b0; stop = 1'b0;
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge HCLK);
    #1 start = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int k = 0;
    while (!halted && k < budget) begin
      @(posedge HCLK); #1;
      k++;
    end
    chk("halt_reached", halted, 1);
  endtask

  task automatic wait_hs(input int n, input int budget);
    int k = 0;
    while (hs_cnt < n && k < budget) begin
      @(posedge HCLK); #1;
      k++;
    end
    chk("handshake_reached", hs_cnt >= n, 1);
  endtask

  initial begin
    int hp;
    HRESET = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b1;
    cmd_ready = 1'b1; cmd_done = 1'b0; cmd_rdata = 8'd0;
    load_prog();
    do_reset();
    chk_en = 1'b1;

    // reset state
    chk("rst_pc", pc, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_fields", {cmd_write, cmd_burst, cmd_sel, cmd_addr, cmd_wdata}, 0);
    chk("rst_last_rdata", last_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);

    // full program, ready=1, done one cycle after handshake
    hs_cnt = 0; lat_wr = 1; lat_rd = 1;
    hp = push_prog(1023);
    chk("model_halt_pc", hp, 35);
    chk("model_cmd_count", exp_q.size(), 36);
    pulse_start();
    chk("start_busy", busy, 1);
    wait_hs(3, 100);
    chk("word0_fields", first_cmd, {1'b1, 3'd0, 1'b1, 10'd1, 8'd1});
    chk("word1_rdata", last_rdata, 8'hA5);
    wait_halt(1000);
    chk("a_cmds", hs_cnt, 36);
    chk("a_pc", pc, 35);
    chk("a_busy", busy, 0);
    chk("a_queue_drained", exp_q.size(), 0);
    chk("a_final_rdata", last_rdata, 8'h17);

    // ready held low for 5 ISSUE cycles, realistic master latency
    do_reset();
    hs_cnt = 0; lat_wr = 2; lat_rd = 5; stall_left = 5; stall_seen = 0;
    hp = push_prog(1023);
    pulse_start();
    wait_halt(3000);
    chk("c_stall_cycles", stall_seen, 5);
    chk("c_cmds", hs_cnt, 36);
    chk("c_pc", pc, 35);

    // stop during WAIT of word 4, then restart
    do_reset();
    hs_cnt = 0; lat_wr = 2; lat_rd = 5;
    hp = push_prog(4);
    chk("model_stop_pc", hp, 4);
    pulse_start();
    wait_hs(5, 200);
    stop = 1'b1;
    wait_halt(200);
    chk("d_pc", pc, 4);
    chk("d_cmds", hs_cnt, 5);
    chk("d_queue_drained", exp_q.size(), 0);
    stop = 1'b0;
    hp = push_prog(1023);
    pulse_start();
    chk("d_restart_pc", pc, 0);
    chk("d_restart_busy", busy, 1);
    chk("d_restart_halted", halted, 0);
    wait_halt(3000);
    chk("d_cmds_total", hs_cnt, 41);
    chk("d_final_pc", pc, 35);

    // zero word at pc 3 halts; done arrives together with ready
    do_reset();
    mem[3] = 23'd0;
    hs_cnt = 0; lat_wr = 0; lat_rd = 0;
    hp = push_prog(1023);
    chk("model_zero_pc", hp, 3);
    chk("model_zero_count", exp_q.size(), 3);
    pulse_start();
    wait_halt(200);
    chk("e_cmds", hs_cnt, 3);
    chk("e_pc", pc, 3);
    chk("e_rdata", last_rdata, 8'hA5);

    // reset in WAIT, master done arrives afterwards
    load_prog();
    do_reset();
    hs_cnt = 0; lat_wr = 2; lat_rd = 5;
    hp = push_prog(1023);
    pulse_start();
    wait_hs(2, 200);
    HRESET = 1'b1;
    @(posedge HCLK);
    #1 HRESET = 1'b0;
    repeat (8) @(posedge HCLK);
    #1;
    chk("f_pc", pc, 0);
    chk("f_cmd_valid", cmd_valid, 0);
    chk("f_busy", busy, 0);
    chk("f_halted", halted, 0);
    chk("f_last_rdata", last_rdata, 0);
    chk("f_cmds", hs_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
